ahb_arbiter: RTL and testbench
==============================

Name: ahb_arbiter

Overview:
Round-robin AHB bus arbiter that drives the master-select index consumed by the master-to-slave multiplexer.
- Grants the shared address/control/write-data path to one of NUM_MASTERS requesters.
- Tracks fixed-length bursts so ownership never changes mid-burst, and honours locked transfers.
- Produces an address-phase owner index (Hmaster) and a data-phase owner index (Hmaster_d) for the write-data and response paths.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..16)
- MASTER_WIDTH, $clog2(NUM_MASTERS), width of master index
- DEFAULT_MASTER, 0, owner granted when no master requests

Ports:
- Hclk  input  1  bus clock, all state on rising edge
- Hreset  input  1  synchronous, active-high reset
- Hbusreq  input  NUM_MASTERS  per-master bus request
- Hlock_M  input  NUM_MASTERS  per-master lock request
- Htrans  input  2  muxed bus HTRANS (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
- Hburst  input  3  muxed bus HBURST (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7)
- Hready  input  1  bus ready, transfer accepted when 1
- Hgrant  output  NUM_MASTERS  one-hot grant, registered
- Hmaster  output  MASTER_WIDTH  address-phase owner index, drives mux select
- Hmaster_d  output  MASTER_WIDTH  data-phase owner index
- Hmastlock  output  1  current address phase is locked

Behaviour:
Reset (Hreset=1 at edge)
- Hgrant=one-hot(DEFAULT_MASTER); Hmaster=Hmaster_d=DEFAULT_MASTER; Hmastlock=0.
- Internal state cleared: burst_rem=0, rr_ptr=DEFAULT_MASTER.
- Reset mid-burst or mid-lock aborts everything; no state survives.

Winner selection (combinational)
- Search from (rr_ptr+1) mod NUM_MASTERS upward, with wrap, for the first asserted Hbusreq.
- If no request is asserted, the winner is DEFAULT_MASTER.

Burst counter (burst_rem = address phases still to come after the current beat), updated only on edges where Hready=1:
- NONSEQ: load length-1 (WRAP4/INCR4→3, WRAP8/INCR8→7, WRAP16/INCR16→15, SINGLE/INCR→0).
- SEQ: decrement, saturating at 0.
- IDLE: clear to 0; this is early termination.
- BUSY: hold.
- burst_rem_next denotes the value after the current edge.

Re-arbitration (Hgrant update)
- Occurs on an edge only when Hready=1, burst_rem_next≤1, and lock_hold=0.
- lock_hold = Hlock_M[grant_idx] & Hbusreq[grant_idx].
- Hgrant <= one-hot(winner). rr_ptr <= winner only if that winner was requesting; otherwise rr_ptr holds.
- With undefined-length bursts (SINGLE/INCR), re-arbitration is allowed on every Hready edge.

Ownership handover
- On every Hready=1 edge: Hmaster <= grant_idx (the pre-edge Hgrant), Hmaster_d <= Hmaster, Hmastlock <= Hlock_M[grant_idx].
- Net effect: grant moves during the last beat's address phase, and the new master takes the address phase after that beat is accepted.
- When Hready=0, all outputs and internal state hold. Wait states never move ownership.

Invariants and simultaneous events
- Hgrant is always exactly one-hot, and grant_idx always equals its encoded index.
- Requests changing while Hready=0 are ignored until the next Hready=1 edge.
- The current owner deasserting Hbusreq mid fixed burst does not release the grant before burst end.
- A lock requested at the same time as burst end keeps the grant with the locking master.

Test Plan:
- Reset: hold Hreset 2 cycles with Hbusreq=4'b1111 → Hgrant=0001, Hmaster=0, Hmaster_d=0, Hmastlock=0; first Hready edge after release grants master 1.
- Round-robin fairness: Hbusreq=4'b1111, SINGLE NONSEQ transfers, Hready=1 continuously → grant sequence 1,2,3,0,1; Hmaster lags Hgrant by 1 cycle, Hmaster_d lags Hmaster by 1.
- Burst protection: master 2 issues INCR8 while master 3 also requests → Hgrant stays 0100 through 6 beats, moves to 1000 on acceptance of beat 7, Hmaster=3 on the cycle after beat 8 is accepted.
- Wait states: during an INCR4 burst hold Hready=0 for 3 cycles on beat 2 → burst_rem, Hgrant, Hmaster unchanged; handover happens exactly 2 beats after Hready returns.
- Early termination: WRAP16 with IDLE issued after beat 5 → burst_rem=0, re-arbitration on that edge to pending master.
- Lock: master 1 asserts Hlock_M[1] across two SINGLE transfers while master 0 requests → Hmastlock=1, grant held on 1; released on the first edge after Hlock_M[1]=0. No requests at all → grant returns to DEFAULT_MASTER=0.

Source files
------------

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with fixed-length burst tracking and locked-transfer support.
// Hgrant moves during the last address phase of a burst; Hmaster follows one accepted
// beat later and Hmaster_d one more beat after that for the write-data/response paths.
module ahb_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned MASTER_WIDTH   = $clog2(NUM_MASTERS),
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic                    Hclk,
  input  logic                    Hreset,
  input  logic [NUM_MASTERS-1:0]  Hbusreq,
  input  logic [NUM_MASTERS-1:0]  Hlock_M,
  input  logic [1:0]              Htrans,
  input  logic [2:0]              Hburst,
  input  logic                    Hready,
  output logic [NUM_MASTERS-1:0]  Hgrant,
  output logic [MASTER_WIDTH-1:0] Hmaster,
  output logic [MASTER_WIDTH-1:0] Hmaster_d,
  output logic                    Hmastlock
);

  localparam logic [1:0] TransIdle   = 2'd0;
  localparam logic [1:0] TransBusy   = 2'd1;
  localparam logic [1:0] TransNonseq = 2'd2;
  localparam logic [1:0] TransSeq    = 2'd3;

  localparam logic [MASTER_WIDTH-1:0] DefIdx   = MASTER_WIDTH'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0]  DefGrant = NUM_MASTERS'(1) << DEFAULT_MASTER;

  logic [3:0]              burst_rem;
  logic [3:0]              burst_rem_next;
  logic [3:0]              burst_load;
  logic [MASTER_WIDTH-1:0] rr_ptr;
  logic [MASTER_WIDTH-1:0] grant_idx;
  logic [MASTER_WIDTH-1:0] winner;
  logic                    lock_hold;
  logic                    rearb;

  // Encode the one-hot grant into the current grant index
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (Hgrant[i]) grant_idx = MASTER_WIDTH'(i);
    end
  end

  // Round-robin search starting just after the last served master; walking the
  // offsets downward lets the nearest requester overwrite farther ones
  always_comb begin
    int j;
    winner = DefIdx;
    j      = 0;
    for (int i = int'(NUM_MASTERS); i >= 1; i--) begin
      j = (int'(rr_ptr) + i) % int'(NUM_MASTERS);
      if (Hbusreq[j]) winner = MASTER_WIDTH'(j);
    end
  end

  // Remaining beats minus one for a burst type; undefined-length bursts count as 0
  always_comb begin
    case (Hburst)
      3'd2, 3'd3: burst_load = 4'd3;
      3'd4, 3'd5: burst_load = 4'd7;
      3'd6, 3'd7: burst_load = 4'd15;
      default:    burst_load = 4'd0;
    endcase
  end

  // Next burst-remaining count; only accepted transfers advance it
  always_comb begin
    burst_rem_next = burst_rem;
    if (Hready) begin
      case (Htrans)
        TransNonseq: burst_rem_next = burst_load;
        TransSeq:    burst_rem_next = (burst_rem == 4'd0) ? 4'd0 : burst_rem - 4'd1;
        TransIdle:   burst_rem_next = 4'd0;
        TransBusy:   burst_rem_next = burst_rem;
        default:     burst_rem_next = burst_rem;
      endcase
    end
  end

  // Re-arbitrate only near burst end and only when the owner is not holding a lock
  always_comb begin
    lock_hold = Hlock_M[grant_idx] & Hbusreq[grant_idx];
    rearb     = Hready & (burst_rem_next <= 4'd1) & ~lock_hold;
  end

  // Grant, ownership pipeline and burst state; everything freezes during wait states
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      Hgrant    <= DefGrant;
      Hmaster   <= DefIdx;
      Hmaster_d <= DefIdx;
      Hmastlock <= 1'b0;
      burst_rem <= 4'd0;
      rr_ptr    <= DefIdx;
    end else if (Hready) begin
      burst_rem <= burst_rem_next;
      Hmaster   <= grant_idx;
      Hmaster_d <= Hmaster;
      Hmastlock <= Hlock_M[grant_idx];
      if (rearb) begin
        Hgrant <= NUM_MASTERS'(1) << winner;
        // A default grant to an idle master must not skew the rotation
        if (Hbusreq[winner]) rr_ptr <= winner;
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: directed scenarios with hand-derived
// expectations, then randomized traffic checked against a cycle-level reference model.
module tb_ahb_arbiter;

  localparam int N   = 4;
  localparam int DEF = 0;

  logic       Hclk = 1'b0;
  logic       Hreset;
  logic [3:0] Hbusreq;
  logic [3:0] Hlock_M;
  logic [1:0] Htrans;
  logic [2:0] Hburst;
  logic       Hready;
  logic [3:0] Hgrant;
  logic [1:0] Hmaster;
  logic [1:0] Hmaster_d;
  logic       Hmastlock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, kept as plain integers
  int m_grant, m_rr, m_rem, m_master, m_master_d;
  bit m_lock;
  int beats[8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  ahb_arbiter #(
    .NUM_MASTERS   (N),
    .MASTER_WIDTH  (2),
    .DEFAULT_MASTER(DEF)
  ) dut (
    .Hclk     (Hclk),
    .Hreset   (Hreset),
    .Hbusreq  (Hbusreq),
    .Hlock_M  (Hlock_M),
    .Htrans   (Htrans),
    .Hburst   (Hburst),
    .Hready   (Hready),
    .Hgrant   (Hgrant),
    .Hmaster  (Hmaster),
    .Hmaster_d(Hmaster_d),
    .Hmastlock(Hmastlock)
  );

  always #5 Hclk = ~Hclk;

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    int nrem, win, k;
    bit hold;
    if (Hreset) begin
      m_grant = DEF; m_rr = DEF; m_rem = 0; m_master = DEF; m_master_d = DEF; m_lock = 0;
      return;
    end
    if (!Hready) return;
    case (Htrans)
      2'd2:    nrem = beats[Hburst] - 1;
      2'd3:    nrem = (m_rem > 0) ? m_rem - 1 : 0;
      2'd0:    nrem = 0;
      default: nrem = m_rem;
    endcase
    win = DEF;
    for (int off = 1; off <= N; off++) begin
      k = (m_rr + off) % N;
      if (Hbusreq[k]) begin
        win = k;
        break;
      end
    end
    hold       = Hlock_M[m_grant] && Hbusreq[m_grant];
    m_master_d = m_master;
    m_master   = m_grant;
    m_lock     = Hlock_M[m_grant];
    if (nrem <= 1 && !hold) begin
      m_grant = win;
      if (Hbusreq[win]) m_rr = win;
    end
    m_rem = nrem;
  endtask

  // One clock: update model, wait for the edge, settle
  task automatic step();
    model_step();
    @(posedge Hclk);
    #1;
  endtask

  task automatic do_reset();
    Hreset = 1; Hbusreq = 4'b0000; Hlock_M = 4'b0000;
    Htrans = 2'd0; Hburst = 3'd0; Hready = 1;
    step(); step();
    Hreset = 0;
  endtask

  task automatic test_reset();
    Hreset = 1; Hbusreq = 4'b1111; Hlock_M = 4'b0000;
    Htrans = 2'd0; Hburst = 3'd0; Hready = 1;
    step(); step();
    n_checks++;
    if (Hgrant !== 4'b0001) $display("FAIL reset_grant: got %b want 0001", Hgrant);
    else n_pass++;
    n_checks++;
    if (Hmaster !== 2'd0 || Hmaster_d !== 2'd0)
      $display("FAIL reset_master: got %0d/%0d want 0/0", Hmaster, Hmaster_d);
    else n_pass++;
    n_checks++;
    if (Hmastlock !== 1'b0) $display("FAIL reset_mastlock: got %b want 0", Hmastlock);
    else n_pass++;
    Hreset = 0;
    step();
    n_checks++;
    if (Hgrant !== 4'b0010) $display("FAIL reset_first_grant: got %b want 0010", Hgrant);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int eg[5] = '{1, 2, 3, 0, 1};
    int em[5] = '{0, 1, 2, 3, 0};
    int ed[5] = '{0, 0, 1, 2, 3};
    do_reset();
    Hbusreq = 4'b1111; Htrans = 2'd2; Hburst = 3'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (Hgrant !== 4'(1 << eg[i]) || Hmaster !== 2'(em[i]) || Hmaster_d !== 2'(ed[i]))
        $display("FAIL rr_seq[%0d]: got g=%b m=%0d md=%0d want g=%0d m=%0d md=%0d",
                 i, Hgrant, Hmaster, Hmaster_d, eg[i], em[i], ed[i]);
      else n_pass++;
    end
  endtask

  task automatic test_burst();
    do_reset();
    Hbusreq = 4'b0100; Htrans = 2'd0;
    step(); step();
    Hburst = 3'd5;
    for (int b = 1; b <= 8; b++) begin
      Htrans  = (b == 1) ? 2'd2 : 2'd3;
      Hbusreq = (b >= 4) ? 4'b1000 : 4'b1100;  // owner drops its request mid-burst
      step();
      n_checks++;
      if (b <= 6 && Hgrant !== 4'b0100)
        $display("FAIL burst_hold[%0d]: got %b want 0100", b, Hgrant);
      else if (b == 7 && (Hgrant !== 4'b1000 || Hmaster !== 2'd2))
        $display("FAIL burst_move: got g=%b m=%0d want g=1000 m=2", Hgrant, Hmaster);
      else if (b == 8 && (Hmaster !== 2'd3 || Hgrant !== 4'b1000))
        $display("FAIL burst_handover: got g=%b m=%0d want g=1000 m=3", Hgrant, Hmaster);
      else n_pass++;
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    Hbusreq = 4'b0010; Htrans = 2'd0;
    step(); step();
    Hbusreq = 4'b0011; Htrans = 2'd2; Hburst = 3'd3;
    step();
    Htrans = 2'd3; Hready = 0; Hbusreq = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (Hgrant !== 4'b0010 || Hmaster !== 2'd1)
        $display("FAIL wait_hold[%0d]: got g=%b m=%0d want g=0010 m=1", i, Hgrant, Hmaster);
      else n_pass++;
    end
    Hready = 1; Hbusreq = 4'b0011;
    step();
    n_checks++;
    if (Hgrant !== 4'b0010) $display("FAIL wait_beat2: got %b want 0010", Hgrant);
    else n_pass++;
    step();
    n_checks++;
    if (Hgrant !== 4'b0001 || Hmaster !== 2'd1)
      $display("FAIL wait_beat3: got g=%b m=%0d want g=0001 m=1", Hgrant, Hmaster);
    else n_pass++;
    step();
    n_checks++;
    if (Hmaster !== 2'd0 || Hmaster_d !== 2'd1)
      $display("FAIL wait_beat4: got m=%0d md=%0d want m=0 md=1", Hmaster, Hmaster_d);
    else n_pass++;
  endtask

  task automatic test_early_term();
    do_reset();
    Hbusreq = 4'b0100; Htrans = 2'd0;
    step(); step();
    Hbusreq = 4'b0101; Hburst = 3'd6;
    for (int b = 1; b <= 5; b++) begin
      Htrans = (b == 1) ? 2'd2 : 2'd3;
      step();
      n_checks++;
      if (Hgrant !== 4'b0100) $display("FAIL early_hold[%0d]: got %b want 0100", b, Hgrant);
      else n_pass++;
    end
    Htrans = 2'd0;
    step();
    n_checks++;
    if (Hgrant !== 4'b0001 || Hmaster !== 2'd2)
      $display("FAIL early_rearb: got g=%b m=%0d want g=0001 m=2", Hgrant, Hmaster);
    else n_pass++;
  endtask

  task automatic test_lock();
    do_reset();
    Hbusreq = 4'b0010; Hlock_M = 4'b0010; Htrans = 2'd0;
    step();
    Hbusreq = 4'b0011; Htrans = 2'd2; Hburst = 3'd0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (Hgrant !== 4'b0010 || Hmastlock !== 1'b1 || Hmaster !== 2'd1)
        $display("FAIL lock_hold[%0d]: got g=%b ml=%b m=%0d want g=0010 ml=1 m=1",
                 i, Hgrant, Hmastlock, Hmaster);
      else n_pass++;
    end
    Hlock_M = 4'b0000;
    step();
    n_checks++;
    if (Hgrant !== 4'b0001 || Hmastlock !== 1'b0)
      $display("FAIL lock_release: got g=%b ml=%b want g=0001 ml=0", Hgrant, Hmastlock);
    else n_pass++;
    Hbusreq = 4'b0100; Htrans = 2'd0;
    step();
    Hbusreq = 4'b0000;
    step();
    n_checks++;
    if (Hgrant !== 4'b0001) $display("FAIL lock_default: got %b want 0001", Hgrant);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] eg;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      Hreset  = ($urandom_range(0, 99) == 0);
      Hbusreq = 4'($urandom_range(0, 15));
      Hlock_M = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      Htrans  = 2'($urandom_range(0, 3));
      Hburst  = 3'($urandom_range(0, 7));
      Hready  = ($urandom_range(0, 3) != 0);
      step();
      eg = 4'(1) << m_grant;
      n_checks++;
      if (Hgrant !== eg) $display("FAIL rand_grant[%0d]: got %b want %b", c, Hgrant, eg);
      else n_pass++;
      n_checks++;
      if (Hmaster !== 2'(m_master) || Hmaster_d !== 2'(m_master_d))
        $display("FAIL rand_master[%0d]: got %0d/%0d want %0d/%0d",
                 c, Hmaster, Hmaster_d, m_master, m_master_d);
      else n_pass++;
      n_checks++;
      if (Hmastlock !== m_lock)
        $display("FAIL rand_mastlock[%0d]: got %b want %b", c, Hmastlock, m_lock);
      else n_pass++;
      n_checks++;
      if ($countones(Hgrant) != 1) $display("FAIL rand_onehot[%0d]: got %b", c, Hgrant);
      else n_pass++;
    end
    Hreset = 0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst();
    test_wait_states();
    test_early_term();
    test_lock();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
